counter_updown_mod: RTL and testbench

- Parametrised synchronous up/down counter. Successor to the fixed 16-bit up-only counter.
- Adds the following over that block:
  - configurable width and terminal value (modulus);
  - direction control;
  - synchronous parallel load;
  - terminal-count output for cascading;
  - sticky overflow/underflow flag.
- Used as a timebase, event counter, or BCD/decade stage in cascaded counter chains.

---
 rtl/counter_updown_mod.sv | 131 +++++++++++++
 tb/tb_counter_updown_mod.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
//
// Parametrised synchronous up/down counter with a modulus of MAX_COUNT+1.
// It supports a synchronous clamped parallel load, a combinational
// terminal-count output for cascading, and a sticky wrap flag.
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   MAX_COUNT  highest count value, 1 <= MAX_COUNT <= 2**WIDTH-1
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset (Q=0, wrap_flag=0)
//   enable      in   count enable; the counter holds while low
//   up_down     in   1 = count up, 0 = count down
//   load        in   synchronous load strobe (has priority over counting)
//   load_value  in   value to load; it is clamped to MAX_COUNT
//   clear_flag  in   synchronous clear of wrap_flag (a wrap on the same edge wins)
//   Q           out  registered count
//   tc          out  combinational terminal count (the next count edge hits the limit)
//   wrap_flag   out  sticky, registered; set on any wrap
//
// Build option:
//   COUNTER_UPDOWN_SATURATE_EN  when defined, the counter saturates at 0 and
//                               MAX_COUNT instead of wrapping. In that build,
//                               tc means "at limit" and wrap_flag records a
//                               lost count.
// -----------------------------------------------------------------------------
module counter_updown_mod #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flag,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap_flag
);

    localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               FULL_RANGE = (MAX_COUNT == ALL_ONES);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    logic             at_max;
    logic             at_zero;
    logic             out_of_range;
    logic             load_over;
    logic [WIDTH-1:0] up_limit_next;
    logic [WIDTH-1:0] down_limit_next;

    assign at_max  = (q_q == MAX_COUNT);
    assign at_zero = (q_q == '0);

    // When MAX_COUNT covers the full range, no value can exceed it. Both
    // comparisons are dropped in that case so that no always-false
    // compare is left in the netlist.
    generate
        if (FULL_RANGE) begin : g_full_range
            assign out_of_range = 1'b0;
            assign load_over    = 1'b0;
        end else begin : g_partial_range
            assign out_of_range = (q_q > MAX_COUNT);
            assign load_over    = (load_value > MAX_COUNT);
        end
    endgenerate

    // Value taken when a count is attempted at a limit.
`ifdef COUNTER_UPDOWN_SATURATE_EN
    assign up_limit_next   = MAX_COUNT;
    assign down_limit_next = '0;
`else
    assign up_limit_next   = '0;
    assign down_limit_next = MAX_COUNT;
`endif

    // tc is high when the next edge counts at a limit. A load masks it
    // because the load replaces the count on that edge.
    assign tc = enable & ~load & ((up_down & at_max) | (~up_down & at_zero));

    // Next-count logic. Priority: load > count > hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_over ? MAX_COUNT : load_value;
        end else if (enable) begin
            if (out_of_range) begin
                // Recovery from a state that only an upset can reach.
                q_d = '0;
            end else if (up_down) begin
                q_d = at_max ? up_limit_next : (q_q + ONE);
            end else begin
                q_d = at_zero ? down_limit_next : (q_q - ONE);
            end
        end
    end

    // Sticky flag: a wrap (or a lost count) on this edge overrides a clear.
    always_comb begin
        wrap_d = wrap_q;
        if (tc) begin
            wrap_d = 1'b1;
        end else if (clear_flag) begin
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q         = q_q;
    assign wrap_flag = wrap_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
`timescale 1ns/1ps
module tb_counter_updown_mod;

`ifdef COUNTER_UPDOWN_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int unsigned MAX4  = 9;
    localparam int unsigned MAX16 = 65535;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit decade instance
    logic       r4, en4, ud4, ld4, clr4;
    logic [3:0] lv4, q4;
    logic       tc4, wf4;
    // 16-bit full-range instance
    logic        r16, en16, ud16, ld16, clr16;
    logic [15:0] lv16, q16;
    logic        tc16, wf16;

    counter_updown_mod #(.WIDTH(4), .MAX_COUNT(4'd9)) u_dut4 (
        .clk(clk), .reset(r4), .enable(en4), .up_down(ud4), .load(ld4),
        .load_value(lv4), .clear_flag(clr4), .Q(q4), .tc(tc4), .wrap_flag(wf4)
    );

    counter_updown_mod u_dut16 (
        .clk(clk), .reset(r16), .enable(en16), .up_down(ud16), .load(ld16),
        .load_value(lv16), .clear_flag(clr16), .Q(q16), .tc(tc16), .wrap_flag(wf16)
    );

    // ---------------- reference model ----------------
    int unsigned m4_q, m16_q;
    bit          m4_f, m16_f;

    // Counting is modulo (maxc+1); saturation clamps to the [0, maxc] range.
    function automatic int unsigned model_next(input int unsigned q, input int unsigned maxc,
                                               input bit en, input bit ud, input bit ld,
                                               input int unsigned lv);
        if (ld) return (lv > maxc) ? maxc : lv;
        if (!en) return q;
        if (q > maxc) return 0;
        if (ud) return SAT ? ((q == maxc) ? maxc : q + 1) : (q + 1) % (maxc + 1);
        return SAT ? ((q == 0) ? 0 : q - 1) : (q + maxc) % (maxc + 1);
    endfunction

    function automatic bit model_limit(input int unsigned q, input int unsigned maxc,
                                       input bit en, input bit ud, input bit ld);
        return en && !ld && (ud ? (q == maxc) : (q == 0));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set4(input bit en, input bit ud, input bit ld, input bit clr, input int unsigned lv);
        en4 = en; ud4 = ud; ld4 = ld; clr4 = clr; lv4 = lv[3:0];
        #1;
    endtask

    task automatic set16(input bit en, input bit ud, input bit ld, input bit clr, input int unsigned lv);
        en16 = en; ud16 = ud; ld16 = ld; clr16 = clr; lv16 = lv[15:0];
        #1;
    endtask

    // Advance one rising edge and step both models from the inputs that were sampled.
    task automatic tick();
        bit l4, l16;
        l4  = model_limit(m4_q, MAX4, en4, ud4, ld4);
        l16 = model_limit(m16_q, MAX16, en16, ud16, ld16);
        @(posedge clk);
        if (r4) begin
            m4_q = 0; m4_f = 1'b0;
        end else begin
            m4_f = l4 ? 1'b1 : (clr4 ? 1'b0 : m4_f);
            m4_q = model_next(m4_q, MAX4, en4, ud4, ld4, {28'd0, lv4});
        end
        if (r16) begin
            m16_q = 0; m16_f = 1'b0;
        end else begin
            m16_f = l16 ? 1'b1 : (clr16 ? 1'b0 : m16_f);
            m16_q = model_next(m16_q, MAX16, en16, ud16, ld16, {16'd0, lv16});
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        r4 = 1'b1; r16 = 1'b1;
        set4(0, 1, 0, 0, 0);
        set16(0, 1, 0, 0, 0);
        m4_q = 0; m4_f = 1'b0; m16_q = 0; m16_f = 1'b0;
        n_cmp++; if (q4 !== 4'd0) begin n_bad++; $display("FAIL reset_q4: got %0d want 0", q4); end
        n_cmp++; if (wf4 !== 1'b0) begin n_bad++; $display("FAIL reset_wf4: got %b want 0", wf4); end
        n_cmp++; if (q16 !== 16'd0) begin n_bad++; $display("FAIL reset_q16: got %h want 0", q16); end
        n_cmp++; if (wf16 !== 1'b0) begin n_bad++; $display("FAIL reset_wf16: got %b want 0", wf16); end
        @(negedge clk);
        r4 = 1'b0; r16 = 1'b0;
        set4(1, 1, 0, 0, 0);
        repeat (5) tick();
        n_cmp++; if (q4 !== 4'd5) begin n_bad++; $display("FAIL reset_precount: got %0d want 5", q4); end
        // Assert reset between clock edges; the outputs must clear at once.
        #2; r4 = 1'b1; #1;
        n_cmp++; if (q4 !== 4'd0) begin n_bad++; $display("FAIL reset_async_q: got %0d want 0", q4); end
        n_cmp++; if (wf4 !== 1'b0) begin n_bad++; $display("FAIL reset_async_wf: got %b want 0", wf4); end
        m4_q = 0; m4_f = 1'b0;
        @(negedge clk); r4 = 1'b0;
        tick();
        n_cmp++; if (q4 !== 4'd1) begin n_bad++; $display("FAIL reset_release: got %0d want 1", q4); end
    endtask

    task automatic test_up_wrap();
        set4(0, 1, 1, 1, 0);
        tick();
        n_cmp++; if (q4 !== 4'd0 || wf4 !== 1'b0) begin n_bad++; $display("FAIL up_init: got q=%0d f=%b want q=0 f=0", q4, wf4); end
        for (int i = 1; i <= 10; i++) begin
            set4(1, 1, 0, 0, 0);
            n_cmp++; if (tc4 !== model_limit(m4_q, MAX4, 1, 1, 0)) begin n_bad++; $display("FAIL up_tc edge %0d: got %b at q=%0d", i, tc4, q4); end
            tick();
            n_cmp++; if (q4 !== m4_q[3:0]) begin n_bad++; $display("FAIL up_q edge %0d: got %0d want %0d", i, q4, m4_q); end
            n_cmp++; if (wf4 !== m4_f) begin n_bad++; $display("FAIL up_flag edge %0d: got %b want %b", i, wf4, m4_f); end
        end
    endtask

    task automatic test_down_wrap();
        set4(0, 0, 1, 1, 2);
        tick();
        n_cmp++; if (q4 !== 4'd2 || wf4 !== 1'b0) begin n_bad++; $display("FAIL down_init: got q=%0d f=%b want q=2 f=0", q4, wf4); end
        for (int i = 1; i <= 3; i++) begin
            set4(1, 0, 0, 0, 0);
            n_cmp++; if (tc4 !== model_limit(m4_q, MAX4, 1, 0, 0)) begin n_bad++; $display("FAIL down_tc edge %0d: got %b at q=%0d", i, tc4, q4); end
            tick();
            n_cmp++; if (q4 !== m4_q[3:0]) begin n_bad++; $display("FAIL down_q edge %0d: got %0d want %0d", i, q4, m4_q); end
            n_cmp++; if (wf4 !== m4_f) begin n_bad++; $display("FAIL down_flag edge %0d: got %b want %b", i, wf4, m4_f); end
        end
    endtask

    task automatic test_load_clamp();
        bit f_before;
        set4(0, 1, 1, 0, 9);
        tick();
        f_before = m4_f;
        set4(1, 1, 1, 0, 4);
        n_cmp++; if (tc4 !== 1'b0) begin n_bad++; $display("FAIL load_tc: got %b want 0", tc4); end
        tick();
        n_cmp++; if (q4 !== 4'd4) begin n_bad++; $display("FAIL load_q: got %0d want 4", q4); end
        n_cmp++; if (wf4 !== f_before) begin n_bad++; $display("FAIL load_flag: got %b want %b", wf4, f_before); end
        set4(1, 1, 1, 0, 15);
        tick();
        n_cmp++; if (q4 !== 4'd9) begin n_bad++; $display("FAIL load_clamp15: got %0d want 9", q4); end
        set4(1, 0, 1, 0, 10);
        tick();
        n_cmp++; if (q4 !== 4'd9) begin n_bad++; $display("FAIL load_clamp10: got %0d want 9", q4); end
    endtask

    task automatic test_flag_collision();
        set4(0, 1, 0, 1, 0);
        tick();
        n_cmp++; if (wf4 !== 1'b0) begin n_bad++; $display("FAIL flag_clear: got %b want 0", wf4); end
        set4(1, 1, 0, 1, 0);
        tick();
        n_cmp++; if (wf4 !== 1'b1) begin n_bad++; $display("FAIL flag_collide: got %b want 1", wf4); end
        n_cmp++; if (q4 !== m4_q[3:0]) begin n_bad++; $display("FAIL flag_collide_q: got %0d want %0d", q4, m4_q); end
        set4(1, 1, 0, 1, 0);
        tick();
        n_cmp++; if (wf4 !== m4_f) begin n_bad++; $display("FAIL flag_next: got %b want %b", wf4, m4_f); end
    endtask

    task automatic test_random4();
        for (int i = 0; i < 400; i++) begin
            set4($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15));
            n_cmp++; if (tc4 !== model_limit(m4_q, MAX4, en4, ud4, ld4)) begin n_bad++; $display("FAIL rand_tc %0d: got %b q=%0d", i, tc4, q4); end
            tick();
            n_cmp++; if (q4 !== m4_q[3:0]) begin n_bad++; $display("FAIL rand_q %0d: got %0d want %0d", i, q4, m4_q); end
            n_cmp++; if (wf4 !== m4_f) begin n_bad++; $display("FAIL rand_flag %0d: got %b want %b", i, wf4, m4_f); end
        end
        set4(0, 0, 0, 0, 0);
    endtask

    task automatic test_full_width();
        set16(0, 1, 1, 1, 16'hFFFF);
        tick();
        n_cmp++; if (q16 !== 16'hFFFF) begin n_bad++; $display("FAIL fw_load: got %h want ffff", q16); end
        for (int i = 0; i < 100; i++) begin
            set16(0, 1, 0, 0, 0);
            n_cmp++; if (tc16 !== 1'b0) begin n_bad++; $display("FAIL fw_hold_tc %0d: got %b want 0", i, tc16); end
            tick();
            n_cmp++; if (q16 !== 16'hFFFF) begin n_bad++; $display("FAIL fw_hold_q %0d: got %h want ffff", i, q16); end
        end
        set16(1, 1, 0, 0, 0);
        n_cmp++; if (tc16 !== 1'b1) begin n_bad++; $display("FAIL fw_tc: got %b want 1", tc16); end
        tick();
        n_cmp++; if (q16 !== m16_q[15:0]) begin n_bad++; $display("FAIL fw_wrap_q: got %h want %h", q16, m16_q); end
        n_cmp++; if (wf16 !== 1'b1) begin n_bad++; $display("FAIL fw_wrap_flag: got %b want 1", wf16); end
        set16(0, 1, 1, 0, 16'h0010);
        tick();
        for (int i = 0; i < 8; i++) begin
            set16(1, (i % 2) == 0, 0, 0, 0);
            tick();
            n_cmp++; if (q16 !== m16_q[15:0]) begin n_bad++; $display("FAIL fw_toggle %0d: got %h want %h", i, q16, m16_q); end
        end
        set16(0, 0, 0, 0, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence / report ----------------
    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_flag_collision();
        test_random4();
        test_full_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
